// File: rtl/fpu_pkg.sv
// Shared widths and FSM encoding for the FPU arbiter slice.
package fpu_pkg;
    localparam int EXP_W = 7;
    localparam int MAN_W = 15;
    localparam int CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;
endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin grant; "last" is the id of the most recently granted requester.
module fpu_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb begin
        grant = req;
        // On contention the requester that was not served last wins.
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/fpu_arbiter.sv
// Arbitrates two requesters onto one shared FPU adder, one operation in flight at a time.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 4,
    parameter int DONE_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [EXP_W-1:0] req0_ae,
    input  logic [EXP_W-1:0] req0_be,
    input  logic [MAN_W-1:0] req0_am,
    input  logic [MAN_W-1:0] req0_bm,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [EXP_W-1:0] req1_ae,
    input  logic [EXP_W-1:0] req1_be,
    input  logic [MAN_W-1:0] req1_am,
    input  logic [MAN_W-1:0] req1_bm,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [EXP_W-1:0] rsp_e,
    output logic [MAN_W-1:0] rsp_m,
    output logic             rsp_err,
    output logic             fpu_add,
    output logic [EXP_W-1:0] fpu_r1e,
    output logic [MAN_W-1:0] fpu_r1m,
    output logic [EXP_W-1:0] fpu_r2e,
    output logic [MAN_W-1:0] fpu_r2m,
    input  logic             fpu_idle,
    input  logic [EXP_W-1:0] fpu_rse,
    input  logic [MAN_W-1:0] fpu_rsm
);
    localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DONE_LIM = CNT_W'(DONE_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic             err_q, err_d;
    logic [EXP_W-1:0] r1e_q, r1e_d, r2e_q, r2e_d;
    logic [MAN_W-1:0] r1m_q, r1m_d, r2m_q, r2m_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;
    logic [EXP_W-1:0] rsp_e_q, rsp_e_d;
    logic [MAN_W-1:0] rsp_m_q, rsp_m_d;
    logic [1:0]       grant;
    logic [1:0]       ready;

    fpu_rr_arb2 u_rr (
        .req   ({req1_valid, req0_valid}),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        err_d       = err_q;
        r1e_d       = r1e_q;
        r1m_d       = r1m_q;
        r2e_d       = r2e_q;
        r2m_d       = r2m_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        rsp_e_d     = rsp_e_q;
        rsp_m_d     = rsp_m_q;
        ready       = 2'b00;
        case (state_q)
            IDLE: begin
                if (fpu_idle && (grant != 2'b00)) begin
                    ready   = grant;
                    last_d  = grant[1];
                    id_d    = grant[1];
                    err_d   = 1'b0;
                    r1e_d   = grant[1] ? req1_ae : req0_ae;
                    r1m_d   = grant[1] ? req1_am : req0_am;
                    r2e_d   = grant[1] ? req1_be : req0_be;
                    r2m_d   = grant[1] ? req1_bm : req0_bm;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                // An FPU that never drops idle is assumed to have finished already.
                if (!fpu_idle) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q >= BUSY_LIM) begin
                    state_d = RESP;
                end
            end
            WAIT_DONE: begin
                if (fpu_idle) begin
                    state_d = RESP;
                end else if (cnt_q >= DONE_LIM) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_err_d   = err_q;
                rsp_e_d     = err_q ? '0 : fpu_rse;
                rsp_m_d     = err_q ? '0 : fpu_rsm;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Counter restarts on every state entry and saturates instead of wrapping.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            err_q       <= 1'b0;
            r1e_q       <= '0;
            r1m_q       <= '0;
            r2e_q       <= '0;
            r2m_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_e_q     <= '0;
            rsp_m_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            id_q        <= id_d;
            err_q       <= err_d;
            r1e_q       <= r1e_d;
            r1m_q       <= r1m_d;
            r2e_q       <= r2e_d;
            r2m_q       <= r2m_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_e_q     <= rsp_e_d;
            rsp_m_q     <= rsp_m_d;
        end
    end

    // Ready is combinational from IDLE, so it is masked to read 0 while reset is held.
    assign req0_ready = ready[0] & ~reset;
    assign req1_ready = ready[1] & ~reset;
    assign fpu_add    = (state_q == ISSUE);
    assign fpu_r1e    = r1e_q;
    assign fpu_r1m    = r1m_q;
    assign fpu_r2e    = r2e_q;
    assign fpu_r2m    = r2m_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_e      = rsp_e_q;
    assign rsp_m      = rsp_m_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Randomised self-checking bench for fpu_arbiter with a transaction-level reference model.
module tb_fpu_arbiter;
    localparam int BT = 4;
    localparam int DT = 1023;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [6:0]  req0_ae, req0_be, req1_ae, req1_be;
    logic [14:0] req0_am, req0_bm, req1_am, req1_bm;
    logic        rsp_valid, rsp_id, rsp_err, fpu_add, fpu_idle;
    logic [6:0]  rsp_e, fpu_r1e, fpu_r2e, fpu_rse;
    logic [14:0] rsp_m, fpu_r1m, fpu_r2m, fpu_rsm;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rem[2];
    logic [6:0]  op_ae[2], op_be[2];
    logic [14:0] op_am[2], op_bm[2];
    int          last_id;

    int          fpu_cfg;
    int          busy_left;
    bit          stuck, release_req, force_low;
    logic [6:0]  res_e;
    logic [14:0] res_m;

    fpu_arbiter #(.BUSY_TIMEOUT(BT), .DONE_TIMEOUT(DT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_ae(req0_ae), .req0_be(req0_be), .req0_am(req0_am), .req0_bm(req0_bm),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_ae(req1_ae), .req1_be(req1_be), .req1_am(req1_am), .req1_bm(req1_bm),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_e(rsp_e), .rsp_m(rsp_m), .rsp_err(rsp_err),
        .fpu_add(fpu_add), .fpu_r1e(fpu_r1e), .fpu_r1m(fpu_r1m), .fpu_r2e(fpu_r2e), .fpu_r2m(fpu_r2m),
        .fpu_idle(fpu_idle), .fpu_rse(fpu_rse), .fpu_rsm(fpu_rsm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FPU model: a positive config drops idle for that many cycles after fpu_add,
    // zero never drops idle, a negative config stays busy until released.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_left <= 0;
            stuck     <= 1'b0;
        end else begin
            if (fpu_add && fpu_cfg > 0) busy_left <= fpu_cfg;
            else if (busy_left > 0) busy_left <= busy_left - 1;
            if (fpu_add && fpu_cfg < 0) stuck <= 1'b1;
            else if (release_req) stuck <= 1'b0;
        end
    end

    assign fpu_idle = (busy_left == 0) && !stuck && !force_low;
    assign fpu_rse  = res_e;
    assign fpu_rsm  = res_m;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_ops(input int g);
        op_ae[g] = 7'($urandom);
        op_be[g] = 7'($urandom);
        op_am[g] = 15'($urandom);
        op_bm[g] = 15'($urandom);
    endtask

    // Drive requester state just after a rising edge, then move to the sampling point.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        req0_valid = (rem[0] > 0);
        req1_valid = (rem[1] > 0);
        req0_ae = op_ae[0]; req0_be = op_be[0]; req0_am = op_am[0]; req0_bm = op_bm[0];
        req1_ae = op_ae[1]; req1_be = op_be[1]; req1_am = op_am[1]; req1_bm = op_bm[1];
        @(negedge clk);
    endtask

    // Ready-to-strobe latency: issue cycle, then either BT idle polls or one busy-detect
    // cycle plus the busy span (capped at DT), then the response cycle and registered strobe.
    function automatic int exp_latency(input int busy);
        if (busy == 0) return 1 + BT + 1 + 1;
        if (busy < 0) return 1 + 1 + DT + 1 + 1;
        return 1 + 1 + busy + 1 + 1;
    endfunction

    task automatic run_txn(input int busy, input logic [6:0] re, input logic [14:0] rm);
        int         exp_g, t0, n, adds, readies;
        bit         got;
        logic [6:0]  eae, ebe;
        logic [14:0] eam, ebm;
        fpu_cfg = busy;
        res_e   = re;
        res_m   = rm;
        exp_g = (rem[0] > 0 && rem[1] > 0) ? ((last_id == 1) ? 0 : 1) : ((rem[0] > 0) ? 0 : 1);
        n = 0;
        while (!(req0_ready || req1_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        got = req0_ready || req1_ready;
        checkOutput("grant_seen", 32'(got), 32'd1);
        if (!got) return;
        checkOutput("grant_id", 32'({req1_ready, req0_ready}), (exp_g == 1) ? 32'd2 : 32'd1);
        t0  = cyc;
        eae = op_ae[exp_g]; ebe = op_be[exp_g]; eam = op_am[exp_g]; ebm = op_bm[exp_g];
        last_id = exp_g;
        rem[exp_g]--;
        new_ops(exp_g);
        applyStimulus();
        adds = 0;
        readies = 0;
        n = 0;
        while (!rsp_valid && n < 1200) begin
            if (fpu_add) adds++;
            if (req0_ready || req1_ready) readies++;
            @(negedge clk);
            n++;
        end
        checkOutput("rsp_seen", 32'(rsp_valid), 32'd1);
        if (!rsp_valid) return;
        checkOutput("latency", 32'(cyc - t0), 32'(exp_latency(busy)));
        checkOutput("rsp_id", 32'(rsp_id), 32'(exp_g));
        checkOutput("rsp_err", 32'(rsp_err), (busy < 0) ? 32'd1 : 32'd0);
        checkOutput("rsp_e", 32'(rsp_e), (busy < 0) ? 32'd0 : 32'(re));
        checkOutput("rsp_m", 32'(rsp_m), (busy < 0) ? 32'd0 : 32'(rm));
        checkOutput("add_pulses", 32'(adds), 32'd1);
        checkOutput("ready_extra", 32'(readies), 32'd0);
        checkOutput("op_r1e", 32'(fpu_r1e), 32'(eae));
        checkOutput("op_r1m", 32'(fpu_r1m), 32'(eam));
        checkOutput("op_r2e", 32'(fpu_r2e), 32'(ebe));
        checkOutput("op_r2m", 32'(fpu_r2m), 32'(ebm));
        if (busy < 0) begin
            @(posedge clk); #1; release_req = 1'b1;
            @(posedge clk); #1; release_req = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, seen;
        reset = 1'b1;
        fpu_cfg = 0; release_req = 1'b0; force_low = 1'b0;
        res_e = '0; res_m = '0;
        rem[0] = 0; rem[1] = 0;
        last_id = 1;
        new_ops(0); new_ops(1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_ae = '0; req0_be = '0; req0_am = '0; req0_bm = '0;
        req1_ae = '0; req1_be = '0; req1_am = '0; req1_bm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_fpu_add", 32'(fpu_add), 32'd0);
        checkOutput("rst_r1m", 32'(fpu_r1m), 32'd0);
        checkOutput("rst_rsp_m", 32'(rsp_m), 32'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);

        // Both requesters held valid from reset: alternation starting with requester 0.
        rem[0] = 2; rem[1] = 2;
        applyStimulus();
        for (int k = 0; k < 4; k++) run_txn($urandom_range(0, 8), 7'($urandom), 15'($urandom));

        // Directed single add with a six-cycle busy FPU.
        rem[0] = 1;
        op_ae[0] = 7'h05; op_am[0] = 15'h4000; op_be[0] = 7'h05; op_bm[0] = 15'h2000;
        applyStimulus();
        run_txn(6, 7'h06, 15'h3000);

        // FPU never drops idle: minimum latency path.
        rem[0] = 1;
        applyStimulus();
        run_txn(0, 7'h01, 15'h0001);

        // FPU stuck busy: error response, then a normal request is accepted.
        rem[1] = 1;
        applyStimulus();
        run_txn(-1, 7'h55, 15'h1234);
        rem[0] = 1;
        applyStimulus();
        run_txn(2, 7'($urandom), 15'($urandom));

        // FPU not idle: no grants; a requester that withdraws is simply skipped.
        force_low = 1'b1;
        rem[0] = 1;
        applyStimulus();
        checkOutput("hold_ready0", 32'(req0_ready), 32'd0);
        rem[0] = 0; rem[1] = 1;
        applyStimulus();
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            if (req0_ready || req1_ready) seen++;
            applyStimulus();
        end
        checkOutput("hold_ready1", 32'(seen), 32'd0);
        @(posedge clk); #1; force_low = 1'b0;
        @(negedge clk);
        run_txn(3, 7'($urandom), 15'($urandom));

        // Reset while waiting on a busy FPU.
        rem[0] = 1;
        fpu_cfg = -1;
        applyStimulus();
        n = 0;
        while (!req0_ready && n < 40) begin @(negedge clk); n++; end
        checkOutput("pre_rst_grant", 32'(req0_ready), 32'd1);
        rem[0] = 0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_fpu_add", 32'(fpu_add), 32'd0);
        checkOutput("mid_rst_r1e", 32'(fpu_r1e), 32'd0);
        checkOutput("mid_rst_r2m", 32'(fpu_r2m), 32'd0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            if (rsp_valid) seen++;
        end
        reset = 1'b0;
        last_id = 1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            if (rsp_valid) seen++;
        end
        checkOutput("rst_no_rsp", 32'(seen), 32'd0);
        rem[0] = 1; rem[1] = 1;
        applyStimulus();
        run_txn(1, 7'($urandom), 15'($urandom));
        run_txn(0, 7'($urandom), 15'($urandom));

        // Randomised traffic with mixed valid patterns and FPU busy spans.
        for (int k = 0; k < 12; k++) begin
            if (rem[0] == 0 && rem[1] == 0) begin
                rem[0] = $urandom_range(0, 2);
                rem[1] = $urandom_range(0, 2);
                if (rem[0] == 0 && rem[1] == 0) rem[$urandom_range(0, 1)] = 1;
                applyStimulus();
            end
            run_txn(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12)),
                    7'($urandom), 15'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 4: cycles after fpu_add to wait for fpu_idle to fall before treating the op as already finished.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 1023: cycles to wait in WAIT_DONE for fpu_idle to rise before aborting with error.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk, reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 reqN_valid  in  1  (N=0,1) requester N has an add pending.
REQ-007 reqN_ready  out  1  (N=0,1) operands of requester N accepted this cycle.
REQ-008 reqN_ae/reqN_be  in  7  (N=0,1) exponents of operands A and B.
REQ-009 reqN_am/reqN_bm  in  15  (N=0,1) mantissas of operands A and B.
REQ-010 rsp_valid  out  1  one-cycle result strobe.
REQ-011 rsp_id  out  1  requester the result belongs to.
REQ-012 rsp_e/rsp_m  out  7/15  result exponent and mantissa.
REQ-013 rsp_err  out  1  DONE_TIMEOUT expired; rsp_e/rsp_m are 0.
REQ-014 fpu_add  out  1  start pulse to the FPU.
REQ-015 fpu_r1e/fpu_r1m/fpu_r2e/fpu_r2m  out  7/15/7/15  FPU operand registers.
REQ-016 fpu_idle  in  1  FPU idle flag.
REQ-017 fpu_rse/fpu_rsm  in  7/15  FPU result.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-019 IDLE: if any reqN_valid and fpu_idle=1, SHALL grant one requester, assert its reqN_ready for exactly one cycle, latch its four operands into fpu_r* registers, and go to ISSUE.
REQ-020 Simultaneous valid SHALL be resolved round-robin: grant the requester not granted last; a single requester is always granted.
REQ-021 IDLE with fpu_idle=0 SHALL grant nobody.
REQ-022 ISSUE SHALL assert fpu_add for exactly one cycle, then go to WAIT_BUSY.
REQ-023 WAIT_BUSY: fpu_idle=0 SHALL go to WAIT_DONE; after BUSY_TIMEOUT cycles with fpu_idle=1, SHALL go to RESP directly.
REQ-024 WAIT_DONE: fpu_idle=1 SHALL go to RESP; after DONE_TIMEOUT cycles, SHALL go to RESP with the error flag set.
REQ-025 RESP SHALL sample fpu_rse/fpu_rsm and pulse rsp_valid for one cycle with rsp_id=granted requester, then return to IDLE.
REQ-026 The earliest new grant SHALL be the cycle after RESP; no back-to-back grant in RESP.
REQ-027 fpu_r* SHALL stay stable from grant until the next grant.
REQ-028 Exactly one operation SHALL be outstanding; reqN_ready SHALL be 0 outside IDLE.
REQ-029 A requester deasserting valid before ready SHALL not be granted; this is no error.
REQ-030 Timeout counters SHALL be 10 bits, cleared on every state entry, and SHALL not wrap.
REQ-031 Minimum latency, ready to rsp_valid, SHALL be 3 + BUSY_TIMEOUT cycles when the FPU never drops idle.

Reset
REQ-032 Reset SHALL force state IDLE and all outputs, fpu_r*, and counters to 0; the last-grant bit resets to 1, so requester 0 wins first.
REQ-033 Reset mid-operation SHALL abort immediately with no rsp_valid and fpu_add low.

Structure
REQ-034 Shared package fpu_pkg SHALL hold EXP_W=7, MAN_W=15, and the FSM state encoding.
REQ-035 Round-robin grant logic SHALL be sub-module fpu_rr_arb2 (inputs req[1:0], last; outputs grant[1:0]).

Verification
REQ-036 req0 only, ae=0x05 am=0x4000 be=0x05 bm=0x2000; FPU model busy 6 cycles, result e=0x06 m=0x3000 -> req0_ready one pulse, fpu_add one pulse, rsp_valid with rsp_id=0, e=0x06, m=0x3000, err=0.
REQ-037 req0 and req1 valid in the same cycle after reset, held -> order 0,1,0,1; each rsp_id matches its grant.
REQ-038 FPU model never drops idle, result e=0x01 m=0x0001 -> rsp_valid exactly 3+4=7 cycles after ready, err=0.
REQ-039 FPU model stays busy forever -> rsp_valid with err=1, e=0, m=0 after 1023 WAIT_DONE cycles; next request then accepted.
REQ-040 reset asserted during WAIT_DONE -> all outputs 0 immediately; no rsp_valid; after release req0 is granted first.
REQ-041 fpu_idle=0 while req1 valid in IDLE -> req1_ready stays 0 until fpu_idle=1.
